pll_lock_rst_seq: RTL and testbench
===================================

Name: pll_lock_rst_seq

Overview:
- Multi-channel successor to the single-PLL clock wrapper.
- Supervises NUM_CH asynchronous PLL lock signals from the fabric CCC instances.
- Qualifies lock with a stability filter, then releases per-domain resets in a fixed staggered order.
- On any lock loss, re-asserts all resets and counts the event. Sits between the CCCs and the subsystem reset tree; runs on one free-running clock.

Parameters:
- NUM_CH, 4, number of PLL lock inputs and reset outputs; must be >= 1.
- LOCK_FILTER, 16, consecutive cycles all locks must be high before release begins; must be >= 1.
- REL_DELAY, 8, cycles between successive channel reset releases; must be >= 1.
- CNT_W, 8, width of the saturating lock-loss counter.
- TIMEOUT_CYC, 65536, WAIT_LOCK timeout in cycles (used only with the optional feature).

Ports:
- CLK  in  1  free-running supervisor clock.
- RESET  in  1  synchronous, active-high reset.
- PLL_LOCK  in  NUM_CH  raw asynchronous PLL lock signals.
- SOFT_RST  in  1  synchronous pulse; forces the full reset sequence to restart.
- CH_RESET  out  NUM_CH  per-domain resets, active high; bit k drives domain k.
- ALL_READY  out  1  high when every CH_RESET bit is released (state RUN).
- LOCK_LOST_CNT  out  CNT_W  saturating count of lock-loss events.
- LOCK_TIMEOUT  out  1  sticky timeout flag; tied 0 without LOCK_TIMEOUT_EN.

Behaviour:
- Interface: one clock, CLK. RESET is synchronous and active-high.
- Reset values: CH_RESET all 1s, ALL_READY 0, LOCK_LOST_CNT 0, LOCK_TIMEOUT 0, state WAIT_LOCK, all counters 0. A RESET mid-operation returns to exactly this state on the next edge.
- Synchronisation: each PLL_LOCK bit passes through a 2-flop synchroniser. lock_all = AND of the synchronised bits.
- WAIT_LOCK:
  - CH_RESET all 1s.
  - If lock_all=1, next state is FILTER with fcnt=0.
- FILTER:
  - If lock_all=0, return to WAIT_LOCK; no count.
  - Else if fcnt==LOCK_FILTER-1, go to RELEASE with dly=0, idx=0.
  - Else fcnt++.
  - FILTER therefore lasts exactly LOCK_FILTER cycles.
- RELEASE:
  - Each cycle dly++.
  - When dly==REL_DELAY-1, clear CH_RESET[idx], set dly=0, idx++.
  - Clearing CH_RESET[NUM_CH-1] moves the state to RUN, and ALL_READY=1 on the same edge.
  - CH_RESET[k] falls (k+1)*REL_DELAY cycles after entering RELEASE.
  - Release order is always bit 0 first, ascending.
- RUN: ALL_READY=1 and CH_RESET all 0s until an exit event.
- Lock loss (lock_all=0 in RELEASE or RUN):
  - Next edge: CH_RESET all 1s, ALL_READY 0, state WAIT_LOCK.
  - LOCK_LOST_CNT++, saturating at 2^CNT_W-1.
- SOFT_RST=1 in FILTER, RELEASE or RUN: same action as lock loss, but no count. In WAIT_LOCK it is ignored.
- Simultaneous lock loss and SOFT_RST: lock loss takes precedence and is counted, once.
- Glitch rejection: a lock glitch shorter than one CLK cycle may be missed; a glitch of one cycle or longer after synchronisation is always acted on.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: LOCK_TIMEOUT_EN.
- When defined:
  - A timer counts cycles spent continuously in WAIT_LOCK; it clears on leaving WAIT_LOCK.
  - When the timer reaches TIMEOUT_CYC-1, LOCK_TIMEOUT is set.
  - LOCK_TIMEOUT is sticky; it clears only on RESET.
  - The sequencer keeps waiting; the flag does not change FSM behaviour.
- When undefined: no timer logic; LOCK_TIMEOUT is constant 0.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum {WAIT_LOCK, FILTER, RELEASE, RUN}.
  - Default parameter constants.
  - clog2-based counter-width helper.
- Sub-module pll_lock_sync: parametrised-width 2-flop synchroniser, one instance of width NUM_CH.

Test Plan (default parameters; cycle numbers count edges after PLL_LOCK is first sampled high):
- Power-up: RESET held 5 cycles, all PLL_LOCK=1 -> CH_RESET=4'b1111 during reset; falls bit by bit at edges 27, 35, 43, 51; ALL_READY=1 at edge 51.
- Filter reject: lock high 10 cycles, low 1 cycle, then high -> no release until 16 clean cycles elapse; LOCK_LOST_CNT stays 0.
- Loss in RUN: drop PLL_LOCK[2] for 3 cycles -> CH_RESET=4'b1111 and ALL_READY=0 within 3 cycles of the drop; LOCK_LOST_CNT=1; full sequence repeats after relock.
- Saturation: CNT_W=2, force 5 losses in RUN -> LOCK_LOST_CNT sticks at 3.
- SOFT_RST during RELEASE after CH_RESET[0] has fallen -> all resets reassert next edge; count unchanged; sequence restarts.
- LOCK_TIMEOUT_EN, TIMEOUT_CYC=100, locks held low -> LOCK_TIMEOUT=1 after 100 cycles in WAIT_LOCK; stays set after lock; cleared only by RESET.

Source files
------------

// File: rtl/pll_lock_rst_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL lock / reset sequencer.
//   - seq_state_e : sequencer states
//   - DEF_*       : default parameter values
//   - cnt_w()     : width of a counter that must hold 0 .. n-1
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_LOCK_FILTER = 16;
  localparam int DEF_REL_DELAY   = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 65536;

  // A counter that only ever holds 0 .. n-1 still needs at least one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_rst_seq_if.sv
// pll_lock_rst_seq_if: signal bundle between the CCC lock outputs, the
// soft-reset source and the subsystem reset tree.
//   pll_lock      : raw asynchronous PLL lock inputs (NUM_CH)
//   soft_rst      : synchronous pulse, restarts the reset sequence
//   ch_reset      : per-domain resets, active high (NUM_CH)
//   all_ready     : every domain out of reset
//   lock_lost_cnt : saturating lock-loss event count (CNT_W)
//   lock_timeout  : sticky WAIT_LOCK timeout flag
// master = driver of lock/soft reset, slave = the sequencer.
interface pll_lock_rst_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0] pll_lock;
  logic              soft_rst;
  logic [NUM_CH-1:0] ch_reset;
  logic              all_ready;
  logic [CNT_W-1:0]  lock_lost_cnt;
  logic              lock_timeout;

  modport master (
    output pll_lock, soft_rst,
    input  ch_reset, all_ready, lock_lost_cnt, lock_timeout
  );

  modport slave (
    input  pll_lock, soft_rst,
    output ch_reset, all_ready, lock_lost_cnt, lock_timeout
  );
endinterface

// File: rtl/pll_lock_rst_seq_sync.sv
// pll_lock_sync: WIDTH-bit two-flop synchroniser for asynchronous lock inputs.
//   clk   : destination clock
//   reset : synchronous active-high reset, clears both stages
//   d     : asynchronous input bits
//   q     : synchronised output bits
module pll_lock_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: supervises NUM_CH PLL lock signals, qualifies them with a
// stability filter and releases the per-domain resets one by one, bit 0 first,
// REL_DELAY cycles apart. Any lock loss while releasing or running re-asserts
// every reset and bumps a saturating counter; soft_rst restarts the sequence
// without counting.
//   clk   : free-running supervisor clock
//   reset : synchronous active-high reset
//   bus   : pll_lock_rst_seq_if slave (lock inputs, soft reset, outputs)
// Optional feature macro LOCK_TIMEOUT_EN: adds a WAIT_LOCK dwell timer that
// sets the sticky lock_timeout flag after TIMEOUT_CYC cycles. Without it,
// lock_timeout is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_LOCK | all resets asserted, waiting for every lock to be high
// FILTER    | all locks high, counting LOCK_FILTER stable cycles
// RELEASE   | dropping ch_reset bits in ascending order, REL_DELAY apart
// RUN       | all domains released, all_ready high
module pll_lock_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int REL_DELAY   = DEF_REL_DELAY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic               clk,
  input logic               reset,
  pll_lock_rst_seq_if.slave bus
);

  localparam int FCNT_W = cnt_w(LOCK_FILTER);
  localparam int DLY_W  = cnt_w(REL_DELAY);
  localparam int IDX_W  = cnt_w(NUM_CH);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(LOCK_FILTER - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(REL_DELAY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 1 || LOCK_FILTER < 1 || REL_DELAY < 1 || CNT_W < 1 ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("pll_lock_rst_seq: parameters must all be >= 1");
  end

  logic [NUM_CH-1:0] lock_sync;
  logic              lock_all;

  seq_state_e        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
  logic              all_ready_q, all_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  pll_lock_sync #(
    .WIDTH (NUM_CH)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.pll_lock),
    .q     (lock_sync)
  );

  assign lock_all = &lock_sync;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    ch_reset_d  = ch_reset_q;
    all_ready_d = all_ready_q;
    cnt_d       = cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        ch_reset_d  = '1;
        all_ready_d = 1'b0;
        if (lock_all) begin
          state_d = FILTER;
          fcnt_d  = '0;
        end
      end

      FILTER: begin
        // Nothing has been released yet, so dropping back costs nothing
        // and is not a counted loss.
        if (!lock_all || bus.soft_rst) begin
          state_d = WAIT_LOCK;
        end else if (fcnt_q == FCNT_LAST) begin
          state_d = RELEASE;
          dly_d   = '0;
          idx_d   = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end

      RELEASE, RUN: begin
        if (!lock_all || bus.soft_rst) begin
          state_d     = WAIT_LOCK;
          ch_reset_d  = '1;
          all_ready_d = 1'b0;
          // Lock loss wins over a coincident soft reset and is counted once.
          if (!lock_all && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (state_q == RELEASE) begin
          if (dly_q == DLY_LAST) begin
            dly_d      = '0;
            ch_reset_d = ch_reset_q & ~(NUM_CH'(1) << idx_q);
            if (idx_q == IDX_LAST) begin
              state_d     = RUN;
              all_ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
      end

      default: begin
        state_d     = WAIT_LOCK;
        ch_reset_d  = '1;
        all_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      fcnt_q      <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
      ch_reset_q  <= '1;
      all_ready_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      ch_reset_q  <= ch_reset_d;
      all_ready_q <= all_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ch_reset      = ch_reset_q;
  assign bus.all_ready     = all_ready_q;
  assign bus.lock_lost_cnt = cnt_q;

`ifdef LOCK_TIMEOUT_EN
  localparam int TMR_W = cnt_w(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_q, timeout_d;

  // Timer holds at its last value once the flag is set; the flag only
  // reports, it never alters sequencing.
  always_comb begin
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
    if (state_q != WAIT_LOCK) begin
      tmr_d = '0;
    end else if (tmr_q == TMR_LAST) begin
      timeout_d = 1'b1;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.lock_timeout = timeout_q;
`else
  assign bus.lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq. Two instances share one stimulus:
// dut uses default parameters, dut_sat narrows the lock-loss counter to 2 bits
// so saturation is reached quickly. With LOCK_TIMEOUT_EN defined, both are
// built with a 100-cycle timeout.
module tb_pll_lock_rst_seq;

`ifdef LOCK_TIMEOUT_EN
  localparam int TO_CYC = 100;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO_CYC = 65536;
  localparam bit TO_EN  = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] pll_lock;
  logic       soft_rst;
  int         total;
  int         bad;

  pll_lock_rst_seq_if #(.NUM_CH(4), .CNT_W(8)) ifm ();
  pll_lock_rst_seq_if #(.NUM_CH(4), .CNT_W(2)) ifs ();

  assign ifm.pll_lock = pll_lock;
  assign ifm.soft_rst = soft_rst;
  assign ifs.pll_lock = pll_lock;
  assign ifs.soft_rst = soft_rst;

  pll_lock_rst_seq #(
    .NUM_CH(4), .LOCK_FILTER(16), .REL_DELAY(8), .CNT_W(8), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.slave)
  );

  pll_lock_rst_seq #(
    .NUM_CH(4), .LOCK_FILTER(16), .REL_DELAY(8), .CNT_W(2), .TIMEOUT_CYC(TO_CYC)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with every lock already high; the next edge is
  // edge 1. Resets fall at edges 27, 35, 43, 51.
  task automatic expect_release(input string tag);
    tick(26);
    chk({tag, "_e26_rst"}, ifm.ch_reset, 4'b1111);
    chk({tag, "_e26_rdy"}, ifm.all_ready, 1'b0);
    tick(1);
    chk({tag, "_e27_rst"}, ifm.ch_reset, 4'b1110);
    tick(8);
    chk({tag, "_e35_rst"}, ifm.ch_reset, 4'b1100);
    tick(8);
    chk({tag, "_e43_rst"}, ifm.ch_reset, 4'b1000);
    tick(7);
    chk({tag, "_e50_rdy"}, ifm.all_ready, 1'b0);
    chk({tag, "_e50_rst"}, ifm.ch_reset, 4'b1000);
    tick(1);
    chk({tag, "_e51_rst"}, ifm.ch_reset, 4'b0000);
    chk({tag, "_e51_rdy"}, ifm.all_ready, 1'b1);
  endtask

  // From RUN: drop one lock for 3 cycles, then relock and re-run the sequence.
  task automatic lose_and_relock(input string tag, input int b,
                                 input int exp_m, input int exp_s);
    pll_lock[b] = 1'b0;
    tick(2);
    chk({tag, "_pre_rst"}, ifm.ch_reset, 4'b0000);
    chk({tag, "_pre_rdy"}, ifm.all_ready, 1'b1);
    tick(1);
    chk({tag, "_rst"}, ifm.ch_reset, 4'b1111);
    chk({tag, "_rdy"}, ifm.all_ready, 1'b0);
    chk({tag, "_cnt"}, ifm.lock_lost_cnt, exp_m);
    chk({tag, "_sat"}, ifs.lock_lost_cnt, exp_s);
    pll_lock = 4'b1111;
    expect_release(tag);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    pll_lock = 4'b1111;
    soft_rst = 1'b0;

    // Power-up
    tick(5);
    chk("rst_ch", ifm.ch_reset, 4'b1111);
    chk("rst_rdy", ifm.all_ready, 1'b0);
    chk("rst_cnt", ifm.lock_lost_cnt, 0);
    chk("rst_to", ifm.lock_timeout, 1'b0);
    reset = 1'b0;
    expect_release("pwr");

    // Lock loss in RUN
    lose_and_relock("loss", 2, 1, 1);
    chk("loss_cnt_after", ifm.lock_lost_cnt, 1);

    // Reset mid-operation clears everything
    reset    = 1'b1;
    pll_lock = 4'b0000;
    tick(1);
    chk("mid_rst_ch", ifm.ch_reset, 4'b1111);
    chk("mid_rst_rdy", ifm.all_ready, 1'b0);
    chk("mid_rst_cnt", ifm.lock_lost_cnt, 0);
    chk("mid_rst_sat", ifs.lock_lost_cnt, 0);
    tick(1);
    reset = 1'b0;
    tick(4);

    // Filter reject: 10 high, 1 low, then high
    pll_lock = 4'b1111;
    tick(10);
    pll_lock = 4'b1101;
    tick(1);
    pll_lock = 4'b1111;
    expect_release("flt");
    chk("flt_cnt", ifm.lock_lost_cnt, 0);

    // Soft reset from RUN, then again during RELEASE after bit 0 fell
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("srun_ch", ifm.ch_reset, 4'b1111);
    chk("srun_rdy", ifm.all_ready, 1'b0);
    chk("srun_cnt", ifm.lock_lost_cnt, 0);
    tick(25);
    chk("srel_b0", ifm.ch_reset, 4'b1110);
    tick(3);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("srel_ch", ifm.ch_reset, 4'b1111);
    chk("srel_cnt", ifm.lock_lost_cnt, 0);
    tick(24);
    chk("srel_r24", ifm.ch_reset, 4'b1111);
    tick(1);
    chk("srel_r25", ifm.ch_reset, 4'b1110);
    tick(24);
    chk("srel_r49_ch", ifm.ch_reset, 4'b0000);
    chk("srel_r49_rdy", ifm.all_ready, 1'b1);

    // Simultaneous lock loss and soft reset: counted once
    pll_lock[1] = 1'b0;
    tick(2);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    chk("sim_ch", ifm.ch_reset, 4'b1111);
    chk("sim_cnt", ifm.lock_lost_cnt, 1);
    chk("sim_sat", ifs.lock_lost_cnt, 1);
    pll_lock = 4'b1111;
    expect_release("sim");

    // Further losses: the 2-bit counter saturates at 3
    lose_and_relock("l2", 0, 2, 2);
    lose_and_relock("l3", 3, 3, 3);
    lose_and_relock("l4", 2, 4, 3);
    lose_and_relock("l5", 1, 5, 3);

    // WAIT_LOCK timeout (tied low in the default build)
    reset    = 1'b1;
    pll_lock = 4'b0000;
    tick(1);
    reset = 1'b0;
    tick(99);
    chk("to_99", ifm.lock_timeout, 1'b0);
    tick(1);
    chk("to_100", ifm.lock_timeout, TO_EN);
    pll_lock = 4'b1111;
    expect_release("to");
    chk("to_sticky", ifm.lock_timeout, TO_EN);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("to_clr", ifm.lock_timeout, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
